fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Decoupling instruction queue between instruction-memory fetch and the IF/ID pipeline register.
//  Fetch pushes {pc, inst, pred_taken} entries; IF/ID pops them when not stalled.
//  A redirect (branch mispredict, jump) flushes all entries in one cycle.
//  Empty queue presents an R-type NOP (32'h00000033) so IF/ID sees a bubble.
// PARAMETERS
//  DEPTH   4    number of entries; power of 2, >=2
//  NOP     32'h00000033   instruction word driven on deq_inst when queue is empty
// PORTS
//  clk            in   1   pipeline clock; all state updates on negedge clk
//  rst            in   1   asynchronous, active-high reset
//  flush          in   1   redirect: discard all entries
//  enq_valid      in   1   fetch has an entry to push
//  enq_ready      out  1   queue can accept (= !full)
//  enq_pc         in   32  PC of fetched instruction
//  enq_inst       in   32  fetched instruction word
//  enq_pred_taken in   1   branch-predictor taken bit for this PC
//  deq_valid      out  1   head entry valid (= !empty)
//  deq_ready      in   1   IF/ID consumes head (driven as !stall)
//  deq_pc         out  32  head PC; 0 when empty
//  deq_inst       out  32  head instruction; NOP when empty
//  deq_pred_taken out  1   head predictor bit; 0 when empty
//  count          out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Storage: DEPTH-entry circular buffer; rd_ptr/wr_ptr are $clog2(DEPTH)+1 bits wide,
//    the MSB being the wrap bit.
//    empty = (rd_ptr == wr_ptr); full = (index bits equal and wrap bits differ).
//  - Reset (async, rst=1): rd_ptr=0, wr_ptr=0, count=0 -> enq_ready=1, deq_valid=0,
//    deq_inst=NOP, deq_pc=0, deq_pred_taken=0. Storage contents are don't-care.
//    Asserting reset mid-operation drops every entry immediately, without waiting for a clock edge.
//  - push = enq_valid & enq_ready; pop = deq_ready & deq_valid. Both are evaluated at negedge clk.
//  - enq_ready depends only on registered state (!full). A full queue refuses a push even if
//    a pop occurs in the same cycle (no pass-through).
//  - No bypass: an entry pushed into an empty queue appears on deq_* one negedge later
//    (latency 1).
//  - Simultaneous push and pop on a non-empty, non-full queue: both pointers advance and
//    count is unchanged.
//  - Pointer wrap: the index wraps modulo DEPTH and the wrap bit toggles.
//    Occupancy stays correct across any number of wraps.
//  - flush=1 at negedge: rd_ptr<=wr_ptr and count<=0. Any push or pop in the same cycle
//    is ignored (flush has priority), so the entry fetched during the redirect cycle is discarded.
//  - deq_* are driven combinationally from the head entry when !empty, else from the
//    reset/bubble values listed above.
//  - deq_ready while empty has no effect. enq_valid while full has no effect, and
//    fetch must hold its entry until enq_ready is seen.
//  - count = wr_ptr - rd_ptr (modulo 2*DEPTH); the range is 0..DEPTH.
// TESTING
//  1. Reset then idle: deq_valid=0, deq_inst=32'h00000033, enq_ready=1, count=0 for 5 cycles.
//  2. Push pc=0x00,0x04,0x08,0x0C (inst 0xA0..0xA3) with deq_ready=0:
//     count=4, enq_ready=0, and a 5th push is refused.
//     Then pop 4 -> entries appear in order 0x00..0x0C.
//  3. Streaming: push and pop every cycle for 20 cycles (5 wraps of DEPTH=4):
//     count stays at 1, and the PC sequence is preserved with no loss or duplication.
//  4. Hold 3 entries, assert flush together with enq_valid(pc=0x40):
//     the next cycle has count=0 and deq_valid=0.
//     A subsequent push of pc=0x80 is the next entry dequeued.
//  5. Full queue with deq_ready=1 and enq_valid=1 in the same cycle:
//     pop succeeds, push is refused, count=3.
//  6. Assert rst asynchronously, between clock edges, while count=2:
//     outputs go to reset values before the next negedge; after release, the first push
//     is dequeued correctly.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between I-mem fetch and IF/ID
// Circular buffer with wrap-bit pointers; state moves on negedge clk, flush drops all entries.
module fetch_queue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000033
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [31:0]                enq_pc,
  input  logic [31:0]                enq_inst,
  input  logic                       enq_pred_taken,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [31:0]                deq_pc,
  output logic [31:0]                deq_inst,
  output logic                       deq_pred_taken,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic          pt_mem   [DEPTH];

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);

  // enq_ready comes from registered pointers only, so a full queue never passes a push through
  assign enq_ready = ~full;
  assign deq_valid = ~empty;
  assign push      = enq_valid & ~full;
  assign pop       = deq_ready & ~empty;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Payload storage is not reset; only the pointers define which slots are live
  always_ff @(negedge clk) begin
    if (push && !flush && !rst) begin
      pc_mem[wr_ptr[AW-1:0]]   <= enq_pc;
      inst_mem[wr_ptr[AW-1:0]] <= enq_inst;
      pt_mem[wr_ptr[AW-1:0]]   <= enq_pred_taken;
    end
  end

  assign count = wr_ptr - rd_ptr;

  always_comb begin
    deq_pc         = 32'h0;
    deq_inst       = NOP;
    deq_pred_taken = 1'b0;
    if (!empty) begin
      deq_pc         = pc_mem[rd_ptr[AW-1:0]];
      deq_inst       = inst_mem[rd_ptr[AW-1:0]];
      deq_pred_taken = pt_mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
// Queue-based reference model checked every cycle, plus directed literal checks.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000033;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [31:0] enq_inst;
  logic        enq_pred_taken;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_inst;
  logic        deq_pred_taken;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_pc(enq_pc), .enq_inst(enq_inst), .enq_pred_taken(enq_pred_taken),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_inst(deq_inst), .deq_pred_taken(deq_pred_taken),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pt;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of entries, updated on the same edge the queue uses
  always @(negedge clk or posedge rst) begin
    bit   do_push;
    bit   do_pop;
    ent_t e;
    if (rst) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      do_push = enq_valid && (q.size() < DEPTH);
      do_pop  = deq_ready && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.pc = enq_pc; e.inst = enq_inst; e.pt = enq_pred_taken;
        q.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cmp_count", 32'(count), 32'(q.size()));
    chk("cmp_enq_ready", 32'(enq_ready), 32'(q.size() < DEPTH));
    chk("cmp_deq_valid", 32'(deq_valid), 32'(q.size() != 0));
    chk("cmp_deq_pc", deq_pc, (q.size() != 0) ? q[0].pc : 32'h0);
    chk("cmp_deq_inst", deq_inst, (q.size() != 0) ? q[0].inst : NOP);
    chk("cmp_deq_pt", 32'(deq_pred_taken), (q.size() != 0) ? 32'(q[0].pt) : 32'h0);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_enq(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic pt);
    enq_valid = v; enq_pc = pc; enq_inst = inst; enq_pred_taken = pt;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; deq_ready = 1'b0;
    set_enq(1'b0, 32'h0, 32'h0, 1'b0);
    cyc(); cyc();
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle_valid", 32'(deq_valid), 32'h0);
      chk("idle_inst", deq_inst, 32'h00000033);
      chk("idle_ready", 32'(enq_ready), 32'h1);
      chk("idle_count", 32'(count), 32'h0);
    end

    // 2: fill, refuse 5th, drain in order
    for (int i = 0; i < 4; i++) begin
      set_enq(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 1'(i));
      cyc();
    end
    chk("fill_count", 32'(count), 32'h4);
    chk("fill_ready", 32'(enq_ready), 32'h0);
    set_enq(1'b1, 32'h10, 32'hA4, 1'b0);
    cyc();
    chk("fifth_refused", 32'(count), 32'h4);
    set_enq(1'b0, 32'h0, 32'h0, 1'b0);
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", deq_pc, 32'(i * 4));
      chk("drain_inst", deq_inst, 32'hA0 + 32'(i));
      cyc();
    end
    chk("drained_valid", 32'(deq_valid), 32'h0);
    deq_ready = 1'b0;

    // 3: streaming across wraps
    set_enq(1'b1, 32'h100, 32'h1000, 1'b0);
    cyc();
    deq_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_enq(1'b1, 32'h104 + 32'(4 * i), 32'h1001 + 32'(i), 1'(i));
      chk("stream_count", 32'(count), 32'h1);
      chk("stream_pc", deq_pc, 32'h100 + 32'(4 * i));
      cyc();
    end
    set_enq(1'b0, 32'h0, 32'h0, 1'b0);
    cyc();
    deq_ready = 1'b0;
    chk("stream_empty", 32'(count), 32'h0);

    // 4: flush with concurrent push
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, 32'h20 + 32'(4 * i), 32'h2000 + 32'(i), 1'b1);
      cyc();
    end
    flush = 1'b1;
    set_enq(1'b1, 32'h40, 32'h4000, 1'b1);
    cyc();
    flush = 1'b0;
    set_enq(1'b0, 32'h0, 32'h0, 1'b0);
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_valid", 32'(deq_valid), 32'h0);
    set_enq(1'b1, 32'h80, 32'h8000, 1'b0);
    cyc();
    set_enq(1'b0, 32'h0, 32'h0, 1'b0);
    chk("post_flush_pc", deq_pc, 32'h80);
    chk("post_flush_count", 32'(count), 32'h1);
    deq_ready = 1'b1;
    cyc();
    deq_ready = 1'b0;

    // 5: full queue, pop and push together
    for (int i = 0; i < 4; i++) begin
      set_enq(1'b1, 32'h200 + 32'(4 * i), 32'h3000 + 32'(i), 1'b0);
      cyc();
    end
    set_enq(1'b1, 32'h300, 32'h3300, 1'b1);
    deq_ready = 1'b1;
    cyc();
    set_enq(1'b0, 32'h0, 32'h0, 1'b0);
    deq_ready = 1'b0;
    chk("full_pp_count", 32'(count), 32'h3);
    chk("full_pp_head", deq_pc, 32'h204);
    deq_ready = 1'b1;
    cyc();
    deq_ready = 1'b0;
    chk("pre_rst_count", 32'(count), 32'h2);

    // 6: asynchronous reset between edges
    #1;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_valid", 32'(deq_valid), 32'h0);
    chk("arst_inst", deq_inst, 32'h00000033);
    chk("arst_pc", deq_pc, 32'h0);
    chk("arst_ready", 32'(enq_ready), 32'h1);
    cyc();
    rst = 1'b0;
    set_enq(1'b1, 32'h500, 32'hDEAD, 1'b1);
    cyc();
    set_enq(1'b0, 32'h0, 32'h0, 1'b0);
    chk("after_rst_pc", deq_pc, 32'h500);
    chk("after_rst_inst", deq_inst, 32'hDEAD);
    chk("after_rst_pt", 32'(deq_pred_taken), 32'h1);
    deq_ready = 1'b1;
    cyc();
    deq_ready = 1'b0;
    chk("final_empty", 32'(deq_valid), 32'h0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
